// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset-release controller:
// sequencer state encoding and elaboration-time parameter legality check.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_DELAY = 2'd0,
        WAIT_ACK   = 2'd1,
        DONE       = 2'd2
    } seq_state_e;

    function automatic bit params_legal(input int num_stages, input int stage_delay);
        return (num_stages >= 1) && (stage_delay >= 1);
    endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES resets in index order: each stage waits STAGE_DELAY cycles,
// then the next stage starts once the current one acks or its ack timeout expires.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 64,
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  reset_done,
    output logic                  timeout_err,
    output logic [IDX_W-1:0]      cur_stage
);

    localparam int CNT_MAX = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    if (!params_legal(NUM_STAGES, STAGE_DELAY)) begin : g_bad_params
        $error("reset_sequencer: NUM_STAGES and STAGE_DELAY must both be >= 1");
    end

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [NUM_STAGES-1:0] sel_mask;
    logic                  advance;

    // One-hot select of the current stage avoids a variable bit index.
    assign sel_mask = NUM_STAGES'(1) << idx_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        err_d     = err_q;
        advance   = 1'b0;

        case (state_q)
            WAIT_DELAY: begin
                if (cnt_q == DLY_LAST) begin
                    rst_out_d = rst_out_q & ~sel_mask;
                    cnt_d     = '0;
                    state_d   = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (|(stage_ack & sel_mask)) begin
                    advance = 1'b1;
                end else if (ACK_TIMEOUT != 0) begin
                    if (cnt_q == TO_LAST) begin
                        advance = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (advance) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = WAIT_DELAY;
                    end
                end
            end
            DONE: ;
            default: state_d = WAIT_DELAY;
        endcase

        // Software restart overrides any ack or timeout seen this cycle.
        if (sw_reset_req) begin
            state_d   = WAIT_DELAY;
            idx_d     = '0;
            cnt_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_DELAY;
            idx_q     <= '0;
            cnt_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign reset_out   = rst_out_q;
    assign reset_done  = done_q;
    assign timeout_err = err_q;
    assign cur_stage   = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected output-change events are queued by the stimulus,
// a negedge monitor pops one per observed change of the selected DUT.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_req = 1'b0;
    logic [3:0] ack_a = 4'hF, ack_b = 4'hF;
    logic [0:0] ack_c = 1'b1;

    logic [3:0] ro_a, ro_b;
    logic [0:0] ro_c;
    logic       done_a, done_b, done_c, err_a, err_b, err_c;
    logic [1:0] cs_a, cs_b;
    logic [0:0] cs_c;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(4), .ACK_TIMEOUT(8)) u_dut_a (
        .clk(clk), .reset(reset), .sw_reset_req(sw_req), .stage_ack(ack_a),
        .reset_out(ro_a), .reset_done(done_a), .timeout_err(err_a), .cur_stage(cs_a));

    reset_sequencer #(.NUM_STAGES(4), .STAGE_DELAY(4), .ACK_TIMEOUT(0)) u_dut_b (
        .clk(clk), .reset(reset), .sw_reset_req(sw_req), .stage_ack(ack_b),
        .reset_out(ro_b), .reset_done(done_b), .timeout_err(err_b), .cur_stage(cs_b));

    reset_sequencer #(.NUM_STAGES(1), .STAGE_DELAY(1), .ACK_TIMEOUT(0)) u_dut_c (
        .clk(clk), .reset(reset), .sw_reset_req(sw_req), .stage_ack(ack_c),
        .reset_out(ro_c), .reset_done(done_c), .timeout_err(err_c), .cur_stage(cs_c));

    typedef struct {
        int       at_edge;
        logic [3:0] ro;
        logic     done;
        logic     err;
        int       cs;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  sel = 0;
    bit  mon_en = 1'b0;
    int  edge_n;

    logic [3:0] obs_ro;
    logic       obs_done, obs_err;
    int         obs_cs;

    // Edge numbering restarts at 1 on the first rising edge after reset drops.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    always_comb begin
        obs_ro = ro_a; obs_done = done_a; obs_err = err_a; obs_cs = int'(cs_a);
        case (sel)
            1: begin obs_ro = ro_b; obs_done = done_b; obs_err = err_b; obs_cs = int'(cs_b); end
            2: begin obs_ro = {3'b000, ro_c}; obs_done = done_c; obs_err = err_c; obs_cs = int'(cs_c); end
            default: ;
        endcase
    end

    initial begin : monitor
        logic [5:0] prev, cur;
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {obs_ro, obs_done, obs_err};
            if (mon_en && cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change edge=%0d ro=%b done=%b err=%b cs=%0d",
                             edge_n, obs_ro, obs_done, obs_err, obs_cs);
                end else begin
                    e = exp_q.pop_front();
                    if (edge_n != e.at_edge || obs_ro !== e.ro || obs_done !== e.done ||
                        obs_err !== e.err || obs_cs != e.cs) begin
                        errors++;
                        $display("FAIL event got edge=%0d ro=%b done=%b err=%b cs=%0d want edge=%0d ro=%b done=%b err=%b cs=%0d",
                                 edge_n, obs_ro, obs_done, obs_err, obs_cs,
                                 e.at_edge, e.ro, e.done, e.err, e.cs);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic exp_ev(input int at_edge, input logic [3:0] ro, input logic done,
                          input logic err, input int cs);
        ev_t e;
        e.at_edge = at_edge; e.ro = ro; e.done = done; e.err = err; e.cs = cs;
        exp_q.push_back(e);
    endtask

    task automatic start_test(input int s);
        mon_en = 1'b0;
        reset  = 1'b1;
        sw_req = 1'b0;
        sel    = s;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        reset  = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        int g;
        g = 0;
        @(negedge clk);
        while (edge_n != n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (edge_n != n) begin
            checks++;
            errors++;
            $display("FAIL wait_edge timeout got edge=%0d want edge=%0d", edge_n, n);
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        repeat (6) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d first_edge=%0d want pending=0",
                     name, exp_q.size(), exp_q[0].at_edge);
            exp_q.delete();
        end
    endtask

    initial begin
        // Acks tied high: releases at 4, 9, 14, 19; done at 20.
        ack_b = 4'hF;
        start_test(1);
        exp_ev(4, 4'b1110, 0, 0, 0);
        exp_ev(9, 4'b1100, 0, 0, 1);
        exp_ev(14, 4'b1000, 0, 0, 2);
        exp_ev(19, 4'b0000, 0, 0, 3);
        exp_ev(20, 4'b0000, 1, 0, 3);
        drain("nominal");

        // Async reset during stage 2's delay, then a full restart from stage 0.
        start_test(1);
        exp_ev(4, 4'b1110, 0, 0, 0);
        exp_ev(9, 4'b1100, 0, 0, 1);
        exp_ev(0, 4'b1111, 0, 0, 0);
        exp_ev(4, 4'b1110, 0, 0, 0);
        exp_ev(9, 4'b1100, 0, 0, 1);
        exp_ev(14, 4'b1000, 0, 0, 2);
        exp_ev(19, 4'b0000, 0, 0, 3);
        exp_ev(20, 4'b0000, 1, 0, 3);
        wait_edge(12);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        drain("async_reset");

        // No timeout: stage 2 waits for its ack, first sampled high at edge 64.
        ack_b = 4'b1011;
        start_test(1);
        exp_ev(4, 4'b1110, 0, 0, 0);
        exp_ev(9, 4'b1100, 0, 0, 1);
        exp_ev(14, 4'b1000, 0, 0, 2);
        exp_ev(68, 4'b0000, 0, 0, 3);
        exp_ev(69, 4'b0000, 1, 0, 3);
        wait_edge(63);
        ack_b = 4'hF;
        drain("long_ack_wait");

        // Timeout of 8 on stage 1, then sw restart in DONE with an ack toggling.
        ack_a = 4'b1101;
        start_test(0);
        exp_ev(4, 4'b1110, 0, 0, 0);
        exp_ev(9, 4'b1100, 0, 0, 1);
        exp_ev(17, 4'b1100, 0, 1, 2);
        exp_ev(21, 4'b1000, 0, 1, 2);
        exp_ev(26, 4'b0000, 0, 1, 3);
        exp_ev(27, 4'b0000, 1, 1, 3);
        wait_edge(29);
        sw_req = 1'b1;
        ack_a  = 4'b0101;
        exp_ev(30, 4'b1111, 0, 0, 0);
        exp_ev(34, 4'b1110, 0, 0, 0);
        exp_ev(39, 4'b1100, 0, 0, 1);
        exp_ev(47, 4'b1100, 0, 1, 2);
        exp_ev(51, 4'b1000, 0, 1, 2);
        exp_ev(56, 4'b0000, 0, 1, 3);
        exp_ev(57, 4'b0000, 1, 1, 3);
        wait_edge(30);
        sw_req = 1'b0;
        ack_a  = 4'b1101;
        drain("timeout_sw_restart");

        // Single stage, single-cycle delay.
        ack_c = 1'b1;
        start_test(2);
        exp_ev(1, 4'b0000, 0, 0, 0);
        exp_ev(2, 4'b0000, 1, 0, 0);
        drain("single_stage");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
